grasspopper_sched: RTL and testbench
====================================

// Module: grasspopper_sched
// PURPOSE
//  Front-end scheduler for the 9-stage grasspopper encode pipeline. Two requesters share the pipeline via round-robin arbitration;
//  one block issued per cycle max. Each issued block carries a 1-bit requester id through a LATENCY-deep tag shift register.
//  Pipeline outputs land in an output FIFO, returned with id; credit check keeps the FIFO from overflowing.
// PARAMETERS
//  DATA_W      256  block width, matches pipeline data_i/data_o
//  LATENCY     9    cycles from enc_data_o sampled to matching enc_data_i valid
//  FIFO_DEPTH  16   output FIFO entries, power of 2, >= 2
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-low
//  req0_valid  in   1       requester 0 offers block
//  req0_ready  out  1       requester 0 block accepted this cycle
//  req0_data   in   DATA_W  requester 0 plaintext
//  req1_valid  in   1       requester 1 offers block
//  req1_ready  out  1       requester 1 block accepted this cycle
//  req1_data   in   DATA_W  requester 1 plaintext
//  enc_data_o  out  DATA_W  to pipeline data_i (registered)
//  enc_data_i  in   DATA_W  from pipeline data_o
//  rsp_valid   out  1       rsp_data/rsp_id valid (FIFO non-empty)
//  rsp_ready   in   1       consumer pops on rsp_valid & rsp_ready
//  rsp_data    out  DATA_W  encoded block, FIFO head
//  rsp_id      out  1       requester that issued the head block
//  busy        out  1       any block in flight or in FIFO
// BEHAVIOUR
//  - reset==0 at clk edge: tag shift register, FIFO pointers/count, in_flight cleared; rr_last=1; enc_data_o=0.
//    Outputs: req*_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. Mid-operation reset drops in-flight and queued blocks silently.
//  - Credit: outstanding = in_flight + fifo_count (registered values). Issue allowed only if outstanding < FIFO_DEPTH.
//    A pop in the same cycle is NOT credited until the next cycle.
//  - Arbitration (combinational):
//      only one valid -> grant it;
//      both valid -> grant !rr_last;
//      no credit or reset -> no grant.
//    reqN_ready = grant to N (may depend on reqN_valid). rr_last <= granted id on each grant.
//  - Issue: on grant, enc_data_o <= granted data. Tag SR bit0 <= {1, id}; otherwise {0, x}, enc_data_o holds its value.
//    Tag SR shifts every cycle.
//  - Retire: tag at depth LATENCY valid -> push {enc_data_i, id} into FIFO in that cycle.
//    Invalid tag -> enc_data_i ignored. in_flight +1 on issue, -1 on retire; both in the same cycle -> unchanged.
//  - FIFO: push and pop in the same cycle allowed at any count, including empty (head bypass not required: empty push shows next cycle)
//    and full (count unchanged). Credit guarantees no push when full; a push at full is a design error (simulation assertion).
//    Pointers wrap modulo FIFO_DEPTH.
//  - rsp_data/rsp_id: head entry; 0 when empty. Order = issue order, independent of id.
//  - busy = (in_flight != 0) | (fifo_count != 0).
//  - Latency: issue on edge N -> enc_data_o valid after N; retire at edge N+LATENCY+1 -> rsp_valid high at N+LATENCY+1 (empty FIFO).
// TESTING
//  T1 reset: hold reset=0 4 cycles with req0_valid=1 -> req0_ready=0, rsp_valid=0, busy=0; release -> req0_ready=1 next cycle.
//  T2 single block: req0 data=0x1 for 1 cycle -> exactly one rsp, rsp_id=0, data = golden encode(0x1), rsp_valid LATENCY+1 cycles after accept.
//  T3 fairness: req0,req1 both held valid 8 cycles -> grants alternate 0,1,0,1..., first grant req0; 8 rsps in issue order with ids 0,1,0,1...
//  T4 backpressure: rsp_ready=0, req0 always valid -> exactly 16 accepts, then req0_ready=0; pop 1 -> exactly 1 further accept.
//  T5 simultaneous push/pop at full: FIFO full, rsp_ready=1 while retire arrives -> count stays 16, no loss, order kept.
//  T6 mid-op reset: 5 blocks in flight, reset=0 1 cycle -> busy=0 next cycle; no stale rsp appears in the following 20 cycles.

Source files
------------

// File: rtl/grasspopper_sched.sv
// Round-robin front end for the 9-stage grasspopper encode pipeline. Each issued block carries
// its requester id through a tag shift register. Results collect in a credit-protected output FIFO.
module grasspopper_sched #(
  parameter int DATA_W     = 256,
  parameter int LATENCY    = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  output logic [DATA_W-1:0] enc_data_o,
  input  logic [DATA_W-1:0] enc_data_i,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   CREDIT_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  function automatic logic parity_f(input logic [DATA_W-1:0] data, input logic id);
    return ^{data, id};
  endfunction

  logic [LATENCY:0]    tag_vld_r;
  logic [LATENCY:0]    tag_id_r;
  logic [DATA_W-1:0]   enc_data_r;
  logic                rr_last_r;
  logic [CNT_W-1:0]    in_flight_r;
  logic [CNT_W-1:0]    fifo_cnt_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [DATA_W-1:0]   mem_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_id_r;
  logic [FIFO_DEPTH-1:0] mem_par_r;

  logic [CNT_W:0]      outstanding_s;
  logic                credit_s;
  logic                grant0_s;
  logic                grant1_s;
  logic                issue_s;
  logic                issue_id_s;
  logic [DATA_W-1:0]   issue_data_s;
  logic                retire_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                rsp_valid_s;
  logic                head_par_ok_s;

  // Credits count blocks still in the pipeline as well as those already queued.
  assign outstanding_s = {1'b0, in_flight_r} + {1'b0, fifo_cnt_r};
  assign credit_s      = (outstanding_s < CREDIT_C);
  assign retire_s      = tag_vld_r[LATENCY];
  assign push_s        = retire_s;
  assign rsp_valid_s   = (fifo_cnt_r != {CNT_W{1'b0}});
  assign pop_s         = rsp_ready & rsp_valid_s;
  assign full_s        = (fifo_cnt_r == FULL_C);
  assign head_par_ok_s = (parity_f(mem_data_r[rd_ptr_r], mem_id_r[rd_ptr_r]) == mem_par_r[rd_ptr_r]);

  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset || !credit_s) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant0_s = rr_last_r;
      grant1_s = ~rr_last_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  assign issue_s      = grant0_s | grant1_s;
  assign issue_id_s   = grant1_s;
  assign issue_data_s = grant1_s ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_vld_r  <= '0;
      tag_id_r   <= '0;
      enc_data_r <= '0;
      rr_last_r  <= 1'b1;
    end else begin
      tag_vld_r <= {tag_vld_r[LATENCY-1:0], issue_s};
      tag_id_r  <= {tag_id_r[LATENCY-1:0], issue_id_s};
      if (issue_s) begin
        enc_data_r <= issue_data_s;
        rr_last_r  <= issue_id_s;
      end else begin
        enc_data_r <= enc_data_r;
        rr_last_r  <= rr_last_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_flight_r <= '0;
    end else begin
      case ({issue_s, retire_s})
        2'b10:   in_flight_r <= in_flight_r + CNT_ONE;
        2'b01:   in_flight_r <= in_flight_r - CNT_ONE;
        default: in_flight_r <= in_flight_r;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible after it has been written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= enc_data_i;
      mem_id_r[wr_ptr_r]   <= tag_id_r[LATENCY];
      mem_par_r[wr_ptr_r]  <= parity_f(enc_data_i, tag_id_r[LATENCY]);
    end
  end

  always_comb begin
    rsp_data = '0;
    rsp_id   = 1'b0;
    if (rsp_valid_s) begin
      rsp_data = mem_data_r[rd_ptr_r];
      rsp_id   = mem_id_r[rd_ptr_r];
    end else begin
      rsp_data = '0;
      rsp_id   = 1'b0;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign enc_data_o = enc_data_r;
  assign rsp_valid  = rsp_valid_s;
  assign busy       = (in_flight_r != {CNT_W{1'b0}}) | rsp_valid_s;

  grasspopper_sched_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .push        (push_s),
    .full        (full_s),
    .head_valid  (rsp_valid_s),
    .head_par_ok (head_par_ok_s)
  );
endmodule

// Safety properties: the credit scheme must never push into a full FIFO, and a visible head
// entry must still carry the parity it was written with.
module grasspopper_sched_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full,
  input logic head_valid,
  input logic head_par_ok
);
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push && full));
  a_head_parity:  assert property (@(posedge clk) disable iff (!reset) (!head_valid || head_par_ok));
endmodule

// File: tb/tb_grasspopper_sched.sv
// Bench for grasspopper_sched: a stand-in 9-stage encode pipeline, a queue-based transaction model
// checked on every cycle, and directed scenarios with hand-computed expectations.
module tb_grasspopper_sched;
  localparam int DW    = 256;
  localparam int LAT   = 9;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] KEY = {8{32'hC0DE_F00D}};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] req0_data = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [DW-1:0] enc_data_o, enc_data_i, rsp_data;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  int acc0 = 0;
  int seen_valid = 0;
  logic glog[$];
  logic rlog[$];

  always #5 clk = ~clk;

  grasspopper_sched #(.DATA_W(DW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .enc_data_o(enc_data_o), .enc_data_i(enc_data_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy)
  );

  function automatic logic [DW-1:0] golden(input logic [DW-1:0] x);
    return {x[DW-9:0], x[DW-1:DW-8]} ^ KEY;
  endfunction

  // Stand-in encode pipeline: LAT register stages fed from enc_data_o.
  logic [DW-1:0] pipe [LAT];
  initial forever begin
    @(posedge clk);
    pipe[0] <= golden(enc_data_o);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign enc_data_i = pipe[LAT-1];

  typedef struct packed { logic id; logic [DW-1:0] data; logic [31:0] retire_at; } xact_t;
  xact_t         inflight_q[$];
  logic [DW:0]   fifo_q[$];
  logic          m_rr_last = 1'b1;
  logic [DW-1:0] m_enc = '0;
  int            cyc = 0;

  // {req1, req0} grant implied by the arbitration rules and the model's credit count
  function automatic logic [1:0] exp_grant();
    int outstanding;
    outstanding = inflight_q.size() + fifo_q.size();
    if (!reset || outstanding >= DEPTH) return 2'b00;
    if (req0_valid && req1_valid) return m_rr_last ? 2'b01 : 2'b10;
    return {req1_valid, req0_valid};
  endfunction

  task automatic model_step();
    logic [1:0] g;
    logic pop;
    xact_t x;
    g = exp_grant();
    pop = rsp_ready && (fifo_q.size() > 0);
    cyc++;
    if (!reset) begin
      inflight_q.delete();
      fifo_q.delete();
      m_rr_last = 1'b1;
      m_enc = '0;
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (inflight_q.size() > 0 && inflight_q[0].retire_at == 32'(cyc)) begin
        x = inflight_q.pop_front();
        fifo_q.push_back({x.id, golden(x.data)});
      end
      if (g != 2'b00) begin
        x.id = g[1];
        x.data = g[1] ? req1_data : req0_data;
        x.retire_at = 32'(cyc + LAT + 1);
        inflight_q.push_back(x);
        m_enc = x.data;
        m_rr_last = g[1];
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_step();
    logic [1:0] g;
    logic ev;
    logic [DW:0] head;
    g = exp_grant();
    ev = (fifo_q.size() > 0);
    head = ev ? fifo_q[0] : '0;
    chk1("req0_ready", req0_ready, g[0]);
    chk1("req1_ready", req1_ready, g[1]);
    chk1("rsp_valid", rsp_valid, ev);
    chk1("rsp_id", rsp_id, head[DW]);
    chkw("rsp_data", rsp_data, head[DW-1:0]);
    chk1("busy", busy, (inflight_q.size() + fifo_q.size()) != 0);
    chkw("enc_data_o", enc_data_o, m_enc);
    if (req0_valid && req0_ready) begin acc0++; glog.push_back(1'b0); end
    if (req1_valid && req1_ready) glog.push_back(1'b1);
    if (rsp_valid && rsp_ready) rlog.push_back(rsp_id);
    if (rsp_valid) seen_valid++;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_step();
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int pack_ids(input int n, input logic q[$]);
    int r;
    r = 0;
    for (int k = 0; k < n && k < q.size(); k++) r |= (int'(q[k]) << k);
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    // T1: reset held four edges with a request pending
    req0_valid = 1'b1;
    req0_data  = 256'h1;
    step(1);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("t1_ready_in_reset", req0_ready, 1'b0);
      chk1("t1_rsp_valid_in_reset", rsp_valid, 1'b0);
      chk1("t1_busy_in_reset", busy, 1'b0);
      step(1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk1("t1_ready_after_release", req0_ready, 1'b1);

    // T2: the single block 0x1 is accepted on this edge
    step(1);
    req0_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 40) begin step(1); k++; end
    chki("t2_latency", k, LAT + 1);
    chkw("t2_data", rsp_data, {{7{32'hC0DE_F00D}}, 32'hC0DE_F10D});
    chk1("t2_id", rsp_id, 1'b0);
    step(15);
    chki("t2_rsp_count", rlog.size(), 1);

    // T3: both requesters held valid for eight cycles after a fresh reset
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    glog.delete();
    rlog.delete();
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data  = 256'(32'hA000_0000 + 32'(i));
      req1_data  = 256'(32'hB000_0000 + 32'(i));
      step(1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step(25);
    chki("t3_grant_count", glog.size(), 8);
    chki("t3_grant_order", pack_ids(8, glog), 32'hAA);
    chki("t3_rsp_count", rlog.size(), 8);
    chki("t3_rsp_id_order", pack_ids(8, rlog), 32'hAA);

    // T4: consumer stalled, requester 0 always offering
    acc0 = 0;
    base = rlog.size();
    rsp_ready  = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req0_data = 256'(32'hC000_0000 + 32'(i));
      step(1);
    end
    chki("t4_accepts_to_full", acc0, DEPTH);
    @(negedge clk);
    chk1("t4_ready_low_when_full", req0_ready, 1'b0);
    step(1);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      req0_data = 256'(32'hD000_0000 + 32'(i));
      step(1);
    end
    chki("t4_accepts_after_one_pop", acc0, DEPTH + 1);
    chk1("t4_fifo_full_again", rsp_valid, 1'b1);

    // T5: full FIFO drained while new blocks keep retiring into it
    rsp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      req0_data = 256'(32'hE000_0000 + 32'(i));
      step(1);
    end
    req0_valid = 1'b0;
    step(40);
    chki("t5_no_loss", rlog.size() - base, acc0);
    @(negedge clk);
    chk1("t5_idle_after_drain", busy, 1'b0);
    step(1);

    // T6: reset with five blocks in flight
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_data = 256'(32'hF000_0000 + 32'(i));
      step(1);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    chk1("t6_busy_before_reset", busy, 1'b1);
    step(1);
    reset = 1'b0;
    step(1);
    chk1("t6_busy_after_reset", busy, 1'b0);
    reset = 1'b1;
    seen_valid = 0;
    step(20);
    chki("t6_stale_rsp", seen_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
